// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
//
// Multi-cycle multiply/divide sequencer for the E stage of the MIPS pipeline.
// A long operation (mult/multu/div/divu) is computed combinationally from the
// operands at the accepting edge and parked in p_hi/p_lo. The unit then stays
// busy for MULT_CYCLES or DIV_CYCLES cycles and commits the result to the
// architectural HI/LO registers on the last of those cycles. mthi/mtlo write
// HI/LO directly when the unit is idle. A D-stage stall keeps later MDU
// instructions out of E while the unit is occupied.
//
// Ports
//   clk        core clock, all state updates on its rising edge
//   reset      synchronous active-low reset
//   start      MDU enable of the instruction currently in E
//   op[2:0]    MDU control: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//              5 mthi, 6 mtlo, 7 none
//   a[31:0]    rs operand (dividend / multiplicand / mthi-mtlo source)
//   b[31:0]    rt operand (divisor / multiplier)
//   d_use_mdu  the instruction in D is an MDU instruction (incl. mfhi/mflo)
//   busy       long operation in flight (registered)
//   stall      freeze PC/F/D and bubble E (combinational)
//   hi, lo     architectural HI and LO (registered)
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_use_mdu,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_NONE7 = 3'b111
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_e      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] p_hi, p_hi_next;
    logic [31:0] p_lo, p_lo_next;
    logic        p_wr, p_wr_next;   // pending result is written at commit
    logic [31:0] hi_next, lo_next;

    mdu_op_e     op_e;
    logic        is_mul, is_long, signed_div;
    logic        accept_long;

    assign op_e       = mdu_op_e'(op);
    assign is_mul     = (op_e == OP_MULT) || (op_e == OP_MULTU);
    assign is_long    = is_mul || (op_e == OP_DIV) || (op_e == OP_DIVU);
    assign signed_div = (op_e == OP_DIV);

    // -----------------------------------------------------------------------
    // Arithmetic on the current operands
    // -----------------------------------------------------------------------
    // The low 64 bits of a product of sign-extended operands equal the
    // two's-complement signed product, so no signed types are needed.
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes and fixes signs afterwards: quotient
    // truncates toward zero, remainder follows the dividend. The magnitude of
    // 0x80000000 is 2^31, which still fits unsigned, so 0x80000000 / -1 yields
    // 0x80000000 with remainder 0 without a special case.
    logic [31:0] dvd, dvs_raw, dvs, q_mag, r_mag, quot, rem;
    assign dvd     = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign dvs_raw = (signed_div && b[31]) ? (~b + 32'd1) : b;
    // A zero divisor is replaced so the divider never sees it; the result is
    // discarded at commit anyway.
    assign dvs     = (b == 32'd0) ? 32'd1 : dvs_raw;
    assign q_mag   = dvd / dvs;
    assign r_mag   = dvd % dvs;
    assign quot    = (signed_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = (signed_div && a[31]) ? (~r_mag + 32'd1) : r_mag;

    logic [31:0] res_hi, res_lo;
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        res_hi = rem;
        res_lo = quot;
        if (op_e == OP_MULT) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else if (op_e == OP_MULTU) begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        p_hi_next   = p_hi;
        p_lo_next   = p_lo;
        p_wr_next   = p_wr;
        hi_next     = hi;
        lo_next     = lo;
        accept_long = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (is_long) begin
                        accept_long = 1'b1;
                    end else if (op_e == OP_MTHI) begin
                        hi_next = a;
                    end else if (op_e == OP_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            RUN: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (p_wr) begin
                        hi_next = p_hi;
                        lo_next = p_lo;
                    end
                    state_next = IDLE;
                    // The commit edge may accept the next long op back to
                    // back; it reads pre-commit HI/LO only via a/b.
                    if (start && is_long) begin
                        accept_long = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept_long) begin
            state_next = RUN;
            cnt_next   = is_mul ? MULT_LOAD : DIV_LOAD;
            p_hi_next  = res_hi;
            p_lo_next  = res_lo;
            p_wr_next  = is_mul || (b != 32'd0);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            p_hi  <= p_hi_next;
            p_lo  <= p_lo_next;
            p_wr  <= p_wr_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    assign busy  = (state == RUN);
    // The start term covers the issue cycle, before busy has risen.
    assign stall = reset && d_use_mdu && (busy || (start && is_long));

endmodule
